pcie_reorder_buf: RTL and testbench
===================================

Name: pcie_reorder_buf

Overview:
- Reassembles out-of-order PCIe write beats into an in-order, address-incrementing stream of W-bit words for the downstream MSM point loader.
- Each PCIe write carries NL lane-slices of W/NL bits at one address. A beat is released only when all NL slices of the beat at the head address have arrived.
- Generalises the two-lane in-order block to NL lanes. Adds per-slot fill bitmaps (no timestamps), a window-overflow check, a duplicate-write check, and a true valid/ready registered output option.

Parameters:
- ADDR_MASK, 64'hffff_ffff_ffff_ffff, mask applied to pcie_a before the region compare.
- ADDR_VAL, 64'h0, region base; a write to exactly this address restarts the stream.
- W, 512, output beat width in bits; a power of 2, ≥ 8·NL.
- NL, 2, lane slices per beat; a power of 2, 1..8.
- D, 512, window depth in beats; a power of 2, ≥ 2.
- REG_O, 0, 0 = combinational output from the RAM read; 1 = registered output stage with full valid/ready.
- Derived: BB = W/8 bytes per beat; SH = log2(BB); D_L = log2(D).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- pcie_v  input  NL  per-lane write strobe.
- pcie_a  input  64  byte address of the beat, BB-aligned.
- pcie_d  input  NL×(W/NL)  lane data; lane g maps to out_d[g·W/NL +: W/NL].
- out_v  output  1  beat valid.
- out_s  output  1  first beat of the stream (out_a == ADDR_VAL).
- out_p  input  1  consumer ready; a transfer occurs when out_v & out_p.
- out_a  output  64  byte address of the presented beat.
- out_d  output  W  beat data.
- err_ovf  output  1  sticky: a write fell outside the window.
- err_dup  output  1  sticky: a lane slice was written twice before being consumed.

Behaviour:
- Reset (rst = 0, async) sets: head index = 0; all bitmaps = 0; out_v = 0, out_s = 0, out_a = ADDR_VAL, out_d = 0, err_ovf = 0, err_dup = 0.
- match = ((pcie_a & ADDR_MASK) == ADDR_VAL) when compared on the masked region bits. Beat index idx = (pcie_a − ADDR_VAL) >> SH, modulo 2^(64−SH). Offset off = idx − head (unsigned).
- Accept a write when match & |pcie_v & off < D. For each g with pcie_v[g]: store pcie_d[g] at slot idx mod D in lane RAM g, and set bitmap[slot][g].
- If match & |pcie_v & off ≥ D: drop the write and set err_ovf.
- If an accepted lane bit is already set: overwrite the data and set err_dup.
- Head slot is complete when all NL bits of bitmap[head mod D] are set.
- out_v = complete(head), qualified by RAM read latency: a slot completed by a write in cycle t gives out_v at t+2 (REG_O=0) or t+3 (REG_O=1) at the earliest. out_a = ADDR_VAL + head·BB.
- Pop (out_v & out_p) clears bitmap[head mod D] and increments head. With REG_O=0, back-to-back complete slots stream at 1 beat/cycle.
- Read address = next head, so the RAM output is valid the cycle after a pop.
- A pop and a write to the same slot in one cycle are impossible, since off < D excludes head+D. A write to head+1 coincident with the pop of head is legal and its lanes are kept.
- REG_O=1: one output register.
  - It loads when empty or when popped in the same cycle.
  - It holds out_a/out_d/out_s stable while out_v & !out_p.
  - Throughput is 1 beat/cycle with out_p held high.
- Restart: pcie_a == ADDR_VAL & |pcie_v.
  - Sets head = 0, clears all bitmaps, err_ovf and err_dup, and empties the output register.
  - The restarting write is then accepted into slot 0 with off = 0.
  - In the restart cycle out_v is forced 0, and any out_p is ignored; no pop.
- Head wraps modulo D in the slot index. out_a keeps incrementing with no wrap within 2^(64−SH) beats.
- Writes with match = 0 are ignored entirely.

Test Plan:
- Test config: W=512, NL=2, D=8, ADDR_VAL=0x1000_0000, out_p=1.
- In-order restart and stream: write 0x1000_0000 both lanes, then +0x40 and +0x80 → out_s=1 on the first beat; out_a = 0x1000_0000, 0x1000_0040, 0x1000_0080 on consecutive cycles; first out_v 2 cycles after its write.
- Split lanes, reversed order: write beat 1 lane 1, beat 1 lane 0, beat 0 lane 0, then beat 0 lane 1 → no out_v until beat 0 lane 1 lands; then beats 0 and 1 emitted back-to-back with correct lane packing.
- Window overflow: after restart with head=0, write beat 8 (0x1000_0200) → err_ovf=1, write dropped. After popping beat 0, a write to beat 8 is accepted with no new error.
- Duplicate: write beat 2 lane 0 twice with data A then B before beat 2 is popped → err_dup=1; out_d lane 0 = B.
- Backpressure (REG_O=1): beats 0–3 complete, out_p low for 5 cycles → out_v=1 with out_a stable at 0x1000_0000. Then out_p=1 → beats 0–3 emitted on 4 consecutive cycles, none lost or repeated.
- Reset and restart mid-stream: rst=0 asynchronously while out_v=1 → out_v=0 immediately. A restart write during the stream → head=0, errors cleared, next output is the new beat 0 with out_s=1.

Source files
------------

// File: rtl/pcie_reorder_buf_if.sv
// pcie_reorder_buf_if: PCIe write-beat input and in-order beat output bundle.
interface pcie_reorder_buf_if #(
    parameter int W  = 512,
    parameter int NL = 2
);
    logic [NL-1:0]             pcie_v;
    logic [63:0]               pcie_a;
    logic [NL-1:0][W/NL-1:0]   pcie_d;
    logic                      out_v;
    logic                      out_s;
    logic                      out_p;
    logic [63:0]               out_a;
    logic [W-1:0]              out_d;
    logic                      err_ovf;
    logic                      err_dup;
    modport master(output pcie_v, pcie_a, pcie_d, out_p,
                   input out_v, out_s, out_a, out_d, err_ovf, err_dup);
    modport slave(input pcie_v, pcie_a, pcie_d, out_p,
                  output out_v, out_s, out_a, out_d, err_ovf, err_dup);
endinterface

// File: rtl/pcie_reorder_buf.sv
// pcie_reorder_buf: reassembles out-of-order NL-lane PCIe write beats into an in-order beat stream.
module pcie_reorder_buf #(
    parameter logic [63:0] ADDR_MASK = 64'hffff_ffff_ffff_ffff,
    parameter logic [63:0] ADDR_VAL  = 64'h0,
    parameter int          W         = 512,
    parameter int          NL        = 2,
    parameter int          D         = 512,
    parameter int          REG_O     = 0
) (
    input logic              clk,
    input logic              rst,
    pcie_reorder_buf_if.slave bus
);
    localparam int BB  = W / 8;
    localparam int SH  = $clog2(BB);
    localparam int D_L = $clog2(D);
    localparam int IW  = 64 - SH;
    localparam int LW  = W / NL;

    logic [LW-1:0]         ram [NL][D];
    logic [NL-1:0]         bm [D];
    logic [NL-1:0][LW-1:0] rd_w;
    logic [IW-1:0]         head, idx, off, nh;
    logic [D_L-1:0]        ws, hs, ns;
    logic [63:0]           rel, head_a, oa_q;
    logic [W-1:0]          rd_q, od_q;
    logic any, match, restart, acc, ovf, dup, comp_q, sv, adv, ov_q, os_q, eo_q, ed_q;

    always_comb begin
        any     = |bus.pcie_v;
        match   = (bus.pcie_a & ADDR_MASK) == (ADDR_VAL & ADDR_MASK);
        restart = any && bus.pcie_a == ADDR_VAL;
        rel     = bus.pcie_a - ADDR_VAL;
        idx     = IW'(rel >> SH);
        off     = idx - (restart ? '0 : head);
        acc     = match && any && off < IW'(D);
        ovf     = match && any && !acc;
        ws      = idx[D_L-1:0];
        hs      = head[D_L-1:0];
        dup     = acc && !restart && |(bus.pcie_v & bm[ws]);
        sv      = comp_q && !restart;
        // with an output register, the head advances when the register loads
        adv     = sv && (REG_O != 0 ? (!ov_q || bus.out_p) : bus.out_p);
        nh      = restart ? '0 : head + IW'(adv);
        ns      = nh[D_L-1:0];
        head_a  = ADDR_VAL + {head, {SH{1'b0}}};
        for (int g = 0; g < NL; g++) rd_w[g] = ram[g][ns];
    end

    always_ff @(posedge clk)
        for (int g = 0; g < NL; g++)
            if (acc && bus.pcie_v[g]) ram[g][ws] <= bus.pcie_d[g];

    // clear-then-set keeps lanes of a write landing in a slot being cleared
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < D; i++) bm[i] <= '0;
        else
            for (int i = 0; i < D; i++)
                bm[i] <= ((restart || (adv && D_L'(i) == hs)) ? '0 : bm[i]) |
                         ((acc && D_L'(i) == ws) ? bus.pcie_v : '0);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            head   <= '0;
            comp_q <= 1'b0;
            rd_q   <= '0;
            eo_q   <= 1'b0;
            ed_q   <= 1'b0;
            ov_q   <= 1'b0;
            os_q   <= 1'b0;
            oa_q   <= ADDR_VAL;
            od_q   <= '0;
        end else begin
            head   <= nh;
            comp_q <= !restart && &bm[ns];
            rd_q   <= rd_w;
            eo_q   <= !restart && (eo_q || ovf);
            ed_q   <= !restart && (ed_q || dup);
            ov_q   <= !restart && (adv || (ov_q && !bus.out_p));
            if (adv) begin
                oa_q <= head_a;
                od_q <= rd_q;
                os_q <= head == '0;
            end
        end

    assign bus.out_v   = REG_O != 0 ? ov_q && !restart : sv;
    assign bus.out_s   = REG_O != 0 ? os_q && bus.out_v : sv && head == '0;
    assign bus.out_a   = REG_O != 0 ? oa_q : head_a;
    assign bus.out_d   = REG_O != 0 ? od_q : rd_q;
    assign bus.err_ovf = eo_q;
    assign bus.err_dup = ed_q;
endmodule

// File: tb/tb_pcie_reorder_buf.sv
// tb_pcie_reorder_buf: directed checks of a combinational-output and a registered-output instance.
module tb_pcie_reorder_buf;
    localparam logic [63:0] AV = 64'h1000_0000;
    localparam logic [63:0] AM = 64'hffff_ffff_f000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] v = '0;
    logic [63:0] a = '0;
    logic [1:0][255:0] d = '0;
    logic p = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pcie_reorder_buf_if #(.W(512), .NL(2)) b0();
    pcie_reorder_buf_if #(.W(512), .NL(2)) b1();

    assign b0.pcie_v = v;
    assign b0.pcie_a = a;
    assign b0.pcie_d = d;
    assign b0.out_p  = p;
    assign b1.pcie_v = v;
    assign b1.pcie_a = a;
    assign b1.pcie_d = d;
    assign b1.out_p  = p;

    pcie_reorder_buf #(.ADDR_MASK(AM), .ADDR_VAL(AV), .W(512), .NL(2), .D(8), .REG_O(0))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    pcie_reorder_buf #(.ADDR_MASK(AM), .ADDR_VAL(AV), .W(512), .NL(2), .D(8), .REG_O(1))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dat(input int k, input int g);
        return 64'hA500_0000 + 64'(k * 16 + g);
    endfunction

    function automatic logic [63:0] ba(input int k);
        return AV + 64'(k) * 64;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int k, input logic [1:0] lanes, input int k0, input int k1);
        v = lanes;
        a = ba(k);
        d[0] = {192'h0, dat(k0, 0)};
        d[1] = {192'h0, dat(k1, 1)};
        tick(1);
        v = '0;
    endtask

    initial begin
        tick(2);
        chk("rst_v0", 64'(b0.out_v), 0);
        chk("rst_v1", 64'(b1.out_v), 0);
        chk("rst_a0", b0.out_a, AV);
        chk("rst_a1", b1.out_a, AV);
        chk("rst_d0", b0.out_d[63:0], 0);
        chk("rst_err", {62'h0, b0.err_ovf, b0.err_dup}, 0);
        rst = 1'b1;
        tick(1);

        // in-order stream after restart
        wr(0, 2'b11, 0, 0);
        chk("io_lat", 64'(b0.out_v), 0);
        wr(1, 2'b11, 1, 1);
        chk("io_v0", 64'(b0.out_v), 1);
        chk("io_s0", 64'(b0.out_s), 1);
        chk("io_a0", b0.out_a, AV);
        chk("io_d0", b0.out_d[63:0], dat(0, 0));
        wr(2, 2'b11, 2, 2);
        chk("io_a1", b0.out_a, AV + 64'h40);
        chk("io_s1", 64'(b0.out_s), 0);
        tick(1);
        chk("io_a2", b0.out_a, AV + 64'h80);
        chk("io_d2", b0.out_d[319:256], dat(2, 1));
        tick(1);
        chk("io_end", 64'(b0.out_v), 0);

        // split lanes in reverse order, head = 3
        wr(4, 2'b10, 4, 4);
        wr(4, 2'b01, 4, 4);
        wr(3, 2'b01, 3, 3);
        tick(2);
        chk("sp_hold", 64'(b0.out_v), 0);
        wr(3, 2'b10, 3, 3);
        chk("sp_lat", 64'(b0.out_v), 0);
        tick(1);
        chk("sp_v3", 64'(b0.out_v), 1);
        chk("sp_a3", b0.out_a, AV + 64'hC0);
        chk("sp_l0_3", b0.out_d[63:0], dat(3, 0));
        chk("sp_l1_3", b0.out_d[319:256], dat(3, 1));
        tick(1);
        chk("sp_a4", b0.out_a, AV + 64'h100);
        chk("sp_l0_4", b0.out_d[63:0], dat(4, 0));
        chk("sp_l1_4", b0.out_d[319:256], dat(4, 1));
        tick(1);
        chk("sp_end", 64'(b0.out_v), 0);

        // window overflow
        wr(0, 2'b11, 0, 0);
        chk("ov_clr", 64'(b0.err_ovf), 0);
        wr(8, 2'b11, 50, 50);
        chk("ov_set", 64'(b0.err_ovf), 1);
        chk("ov_a0", b0.out_a, AV);
        tick(1);
        wr(8, 2'b11, 8, 8);
        for (int k = 1; k < 8; k++) wr(k, 2'b11, k, k);
        tick(1);
        chk("ov_a7", b0.out_a, AV + 64'h1C0);
        tick(1);
        chk("ov_v8", 64'(b0.out_v), 1);
        chk("ov_a8", b0.out_a, AV + 64'h200);
        chk("ov_d8", b0.out_d[63:0], dat(8, 0));
        chk("ov_nodup", 64'(b0.err_dup), 0);
        tick(1);

        // duplicate lane write, head = 9
        wr(9, 2'b01, 9, 9);
        chk("dp_none", 64'(b0.err_dup), 0);
        wr(9, 2'b01, 30, 30);
        chk("dp_set", 64'(b0.err_dup), 1);
        wr(9, 2'b10, 9, 9);
        tick(1);
        chk("dp_v", 64'(b0.out_v), 1);
        chk("dp_l0", b0.out_d[63:0], dat(30, 0));
        chk("dp_l1", b0.out_d[319:256], dat(9, 1));
        tick(1);

        // backpressure on the registered output
        p = 1'b0;
        wr(0, 2'b11, 0, 0);
        chk("bp_eclr", {62'h0, b0.err_ovf, b0.err_dup}, 0);
        for (int k = 1; k < 4; k++) wr(k, 2'b11, k, k);
        chk("bp_v", 64'(b1.out_v), 1);
        chk("bp_s", 64'(b1.out_s), 1);
        tick(5);
        chk("bp_hold_v", 64'(b1.out_v), 1);
        chk("bp_hold_a", b1.out_a, AV);
        chk("bp_hold_d", b1.out_d[63:0], dat(0, 0));
        p = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_sv", 64'(b1.out_v), 1);
            chk("bp_sa", b1.out_a, ba(k));
            chk("bp_sd", b1.out_d[319:256], dat(k, 1));
            tick(1);
        end
        chk("bp_end", 64'(b1.out_v), 0);

        // restart mid-stream, then async reset while valid
        wr(4, 2'b11, 4, 4);
        wr(5, 2'b11, 5, 5);
        wr(6, 2'b11, 6, 6);
        chk("rs_pre", b0.out_a, AV + 64'h140);
        p = 1'b0;
        v = 2'b11;
        a = AV;
        d[0] = {192'h0, dat(20, 0)};
        d[1] = {192'h0, dat(20, 1)};
        #1;
        chk("rs_force", 64'(b0.out_v), 0);
        @(posedge clk);
        #1;
        v = '0;
        chk("rs_gap", 64'(b0.out_v), 0);
        tick(1);
        chk("rs_v", 64'(b0.out_v), 1);
        chk("rs_s", 64'(b0.out_s), 1);
        chk("rs_a", b0.out_a, AV);
        chk("rs_d", b0.out_d[63:0], dat(20, 0));
        tick(2);
        chk("ar_pre", 64'(b1.out_v), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_v0", 64'(b0.out_v), 0);
        chk("ar_v1", 64'(b1.out_v), 0);
        chk("ar_a1", b1.out_a, AV);
        tick(1);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
